// File: rtl/pa_f_spsram_64x44_ctrl.sv
// pa_f_spsram_64x44_ctrl
//   Access controller for a 64x44 single-port SRAM. It drives the SRAM
//   A/CEN/GWEN/WEN/D pins. After reset, or when clr_req is taken, it first
//   writes zero to every entry. It then turns a request channel into SRAM
//   write-with-bit-mask and read cycles, and returns read data on a response
//   channel straight from the SRAM Q output.
//
//   Handshake rule, used on both channels: a transfer happens in a cycle where
//   valid and ready are both high at the rising clock edge. A source holds
//   valid and its payload stable until that transfer happens.
//
// Ports
//   CLK, RST                 clock shared with the SRAM; synchronous
//                            active-high reset
//   clr_req                  pulse that re-clears the array (IDLE, or RESP
//                            with rsp_rdy=1)
//   init_done                high when the array is cleared and usable
//   req_vld/req_rdy          request handshake
//   req_wr                   1 = write, 0 = read
//   req_addr                 entry index for the request
//   req_wdata/req_wmask      write data, and the per-bit write mask
//                            (1 = write this bit)
//   rsp_vld/rsp_rdy          read response handshake
//   rsp_data                 read data, equal to Q
//   A/CEN/GWEN/WEN/D/Q       SRAM pins; CEN/GWEN/WEN are active-low
//   state_dbg                current FSM state (0 INIT, 1 IDLE, 2 RESP)

module pa_f_spsram_64x44_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 44
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr_req,
  output logic                  init_done,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic                  GWEN,
  output logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;

  // High when the controller can take a new request this cycle.
  logic                  accept_ok;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    accept_ok  = 1'b0;
    init_done  = 1'b0;
    req_rdy    = 1'b0;
    rsp_vld    = 1'b0;
    CEN        = 1'b1;
    GWEN       = 1'b1;
    WEN        = '1;
    D          = '0;
    A          = req_addr;

    if (!RST) begin
      case (state_q)
        ST_INIT: begin
          // Write zero to one entry per cycle. The counter wraps to 0 on the
          // last entry, so it is already 0 when the next clear starts.
          CEN        = 1'b0;
          GWEN       = 1'b0;
          WEN        = '0;
          D          = '0;
          A          = init_cnt_q;
          init_cnt_d = init_cnt_q + 1'b1;
          if (init_cnt_q == {ADDR_WIDTH{1'b1}}) begin
            state_d = ST_IDLE;
          end
        end
        ST_IDLE: begin
          init_done = 1'b1;
          if (clr_req) begin
            state_d = ST_INIT;
          end else begin
            accept_ok = 1'b1;
          end
        end
        ST_RESP: begin
          init_done = 1'b1;
          rsp_vld   = 1'b1;
          // While the response stalls, CEN stays high. The SRAM then keeps
          // the read address, so Q stays stable without a local copy.
          if (rsp_rdy) begin
            if (clr_req) begin
              state_d = ST_INIT;
            end else begin
              state_d   = ST_IDLE;
              accept_ok = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_INIT;
        end
      endcase

      if (accept_ok) begin
        req_rdy = 1'b1;
        if (req_vld) begin
          CEN = 1'b0;
          A   = req_addr;
          if (req_wr) begin
            GWEN    = 1'b0;
            WEN     = ~req_wmask;
            D       = req_wdata;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign rsp_data  = Q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pa_f_spsram_64x44_ctrl.sv
// Directed testbench for pa_f_spsram_64x44_ctrl with a behavioural
// address-holding 64x44 SRAM model attached to the SRAM pins.
module tb_pa_f_spsram_64x44_ctrl;

  localparam int AW = 6;
  localparam int DW = 44;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic          clr_req = 1'b0;
  logic          init_done;
  logic          req_vld = 1'b0;
  logic          req_rdy;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] req_wmask = '0;
  logic          rsp_vld;
  logic          rsp_rdy = 1'b1;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] A;
  logic          CEN;
  logic          GWEN;
  logic [DW-1:0] WEN;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  pa_f_spsram_64x44_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .clr_req(clr_req), .init_done(init_done),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
    .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D), .Q(Q),
    .state_dbg(state_dbg)
  );

  // ---------------- SRAM model ----------------
  // Q updates only on a read. With CEN=1 it holds its last value.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] q_r = '0;
  assign Q = q_r;
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom};
  end
  always @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) mem[A] <= (mem[A] & WEN) | (D & ~WEN);
      else       q_r    <= mem[A];
    end
  end

  // ---------------- driver helpers ----------------
  // Step past the next rising edge. Inputs change here, and outputs are
  // checked after a further 2 ns.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Count cycles until init_done rises, with a bound.
  task automatic wait_init(input int exp_cycles, input string name);
    int n;
    n = 0;
    settle();
    while (!init_done && n < 200) begin
      tick();
      settle();
      n++;
    end
    n_checks++;
    if (n !== exp_cycles) begin
      n_fail++;
      $display("FAIL %s: init_done after %0d cycles, expected %0d", name, n, exp_cycles);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [DW-1:0] mask);
    req_vld = 1'b1; req_wr = 1'b1; req_addr = addr; req_wdata = data; req_wmask = mask;
    settle();
    n_checks++;
    if (req_rdy !== 1'b1 || CEN !== 1'b0 || GWEN !== 1'b0 || A !== addr ||
        WEN !== ~mask || D !== data) begin
      n_fail++;
      $display("FAIL write_pins: rdy=%b cen=%b gwen=%b a=%0d wen=%h d=%h, expected 1 0 0 %0d %h %h",
               req_rdy, CEN, GWEN, A, WEN, D, addr, ~mask, data);
    end
    tick();
    req_vld = 1'b0; req_wr = 1'b0;
  endtask

  // Read one entry with rsp_rdy=1 and check the response in the next cycle.
  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp,
                         input string name);
    rsp_rdy = 1'b1;
    req_vld = 1'b1; req_wr = 1'b0; req_addr = addr;
    settle();
    n_checks++;
    if (req_rdy !== 1'b1 || CEN !== 1'b0 || GWEN !== 1'b1 || A !== addr) begin
      n_fail++;
      $display("FAIL %s_req: rdy=%b cen=%b gwen=%b a=%0d, expected 1 0 1 %0d",
               name, req_rdy, CEN, GWEN, A, addr);
    end
    tick();
    req_vld = 1'b0;
    settle();
    n_checks++;
    if (rsp_vld !== 1'b1 || rsp_data !== exp) begin
      n_fail++;
      $display("FAIL %s_rsp: vld=%b data=%h, expected 1 %h", name, rsp_vld, rsp_data, exp);
    end
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b1;
    req_vld = 1'b1;  // must be ignored during reset and INIT
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      n_checks++;
      if (CEN !== 1'b1 || GWEN !== 1'b1 || WEN !== {DW{1'b1}} || init_done !== 1'b0 ||
          req_rdy !== 1'b0 || rsp_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: cen=%b gwen=%b wen=%h done=%b rdy=%b vld=%b",
                 CEN, GWEN, WEN, init_done, req_rdy, rsp_vld);
      end
    end
    n_checks++;
    if (state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d expected 0", state_dbg);
    end
    tick();
    RST = 1'b0;
    // 64 clear writes to A=0..63, one per cycle.
    for (int i = 0; i < 64; i++) begin
      settle();
      n_checks++;
      if (CEN !== 1'b0 || GWEN !== 1'b0 || WEN !== '0 || D !== '0 || A !== i[AW-1:0] ||
          init_done !== 1'b0 || req_rdy !== 1'b0 || rsp_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL init_cycle%0d: cen=%b gwen=%b wen=%h d=%h a=%0d done=%b rdy=%b",
                 i, CEN, GWEN, WEN, D, A, init_done, req_rdy);
      end
      tick();
    end
    req_vld = 1'b0;
    settle();
    n_checks++;
    if (init_done !== 1'b1 || state_dbg !== 2'd1) begin
      n_fail++;
      $display("FAIL init_done_cycle65: done=%b state=%0d, expected 1 1", init_done, state_dbg);
    end
    do_read(6'd37, '0, "read_cleared37");
  endtask

  task automatic test_masked_write();
    do_write(6'd5, 44'hFFF_FFFF_FFFF, 44'h000_0000_FFFF);
    do_read(6'd5, 44'h000_0000_FFFF, "masked_read5");
    // A fully masked write still enables the SRAM but changes nothing.
    do_write(6'd5, 44'hFFF_FFFF_FFFF, 44'h0);
    do_read(6'd5, 44'h000_0000_FFFF, "zero_mask_read5");
  endtask

  task automatic test_back_pressure();
    do_write(6'd6, 44'h123_4567_89AB, {DW{1'b1}});
    rsp_rdy = 1'b0;
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 6'd5;
    tick();
    req_addr = 6'd6;  // next read waits while the response stalls
    for (int i = 0; i < 4; i++) begin
      settle();
      n_checks++;
      if (rsp_vld !== 1'b1 || rsp_data !== 44'h000_0000_FFFF || req_rdy !== 1'b0 ||
          CEN !== 1'b1) begin
        n_fail++;
        $display("FAIL stall%0d: vld=%b data=%h rdy=%b cen=%b, expected 1 ffff 0 1",
                 i, rsp_vld, rsp_data, req_rdy, CEN);
      end
      tick();
    end
    rsp_rdy = 1'b1;
    settle();
    n_checks++;
    if (rsp_vld !== 1'b1 || req_rdy !== 1'b1 || CEN !== 1'b0 || A !== 6'd6) begin
      n_fail++;
      $display("FAIL release: vld=%b rdy=%b cen=%b a=%0d, expected 1 1 0 6",
               rsp_vld, req_rdy, CEN, A);
    end
    tick();
    req_vld = 1'b0;
    settle();
    n_checks++;
    if (rsp_vld !== 1'b1 || rsp_data !== 44'h123_4567_89AB) begin
      n_fail++;
      $display("FAIL read6_after_stall: vld=%b data=%h, expected 1 123456789ab", rsp_vld, rsp_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] v;
    logic [DW-1:0] got;
    for (int i = 0; i < 8; i++) begin
      v = 44'hA00_0000_0000 | DW'(i * 17 + 3);
      do_write(i[AW-1:0], v, {DW{1'b1}});
    end
    rsp_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_vld = 1'b1; req_wr = 1'b0; req_addr = i[AW-1:0];
      settle();
      n_checks++;
      if (req_rdy !== 1'b1 || CEN !== 1'b0 || (i > 0 && rsp_vld !== 1'b1)) begin
        n_fail++;
        $display("FAIL stream_req%0d: rdy=%b cen=%b vld=%b", i, req_rdy, CEN, rsp_vld);
      end
      if (i > 0 && exp_q.size() > 0) begin
        got = exp_q.pop_front();
        n_checks++;
        if (rsp_data !== got) begin
          n_fail++;
          $display("FAIL stream_rsp%0d: data=%h expected %h", i - 1, rsp_data, got);
        end
      end
      exp_q.push_back(44'hA00_0000_0000 | DW'(i * 17 + 3));
      tick();
    end
    req_vld = 1'b0;
    settle();
    got = exp_q.pop_front();
    n_checks++;
    if (rsp_vld !== 1'b1 || rsp_data !== got) begin
      n_fail++;
      $display("FAIL stream_rsp7: vld=%b data=%h expected %h", rsp_vld, rsp_data, got);
    end
    tick();
  endtask

  task automatic test_clear_req();
    do_write(6'd63, 44'hABC, {DW{1'b1}});
    clr_req = 1'b1;
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 6'd63;
    settle();
    n_checks++;
    if (req_rdy !== 1'b0 || CEN !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_idle: rdy=%b cen=%b, expected 0 1", req_rdy, CEN);
    end
    tick();
    clr_req = 1'b0; req_vld = 1'b0;
    settle();
    n_checks++;
    if (CEN !== 1'b0 || A !== 6'd0 || init_done !== 1'b0 || rsp_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_start: cen=%b a=%0d done=%b vld=%b, expected 0 0 0 0",
               CEN, A, init_done, rsp_vld);
    end
    wait_init(64, "clr_idle_time");
    do_read(6'd63, '0, "read63_after_clr");
  endtask

  task automatic test_clear_in_resp();
    do_write(6'd9, 44'h555, {DW{1'b1}});
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 6'd9; rsp_rdy = 1'b1;
    tick();
    clr_req = 1'b1;
    settle();
    n_checks++;
    if (rsp_vld !== 1'b1 || rsp_data !== 44'h555 || req_rdy !== 1'b0 || CEN !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_resp: vld=%b data=%h rdy=%b cen=%b, expected 1 555 0 1",
               rsp_vld, rsp_data, req_rdy, CEN);
    end
    tick();
    clr_req = 1'b0; req_vld = 1'b0;
    wait_init(64, "clr_resp_time");
  endtask

  task automatic test_mid_clear_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    settle();
    n_checks++;
    if (A !== 6'd20 || CEN !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_clear_pos: a=%0d cen=%b, expected 20 0", A, CEN);
    end
    RST = 1'b1;
    settle();
    n_checks++;
    if (CEN !== 1'b1 || init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_clear_rst: cen=%b done=%b, expected 1 0", CEN, init_done);
    end
    tick();
    RST = 1'b0;
    settle();
    n_checks++;
    if (A !== 6'd0 || CEN !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_clear_restart: a=%0d cen=%b, expected 0 0", A, CEN);
    end
    wait_init(64, "mid_clear_time");
  endtask

  initial begin
    test_reset();
    test_masked_write();
    test_back_pressure();
    test_back_to_back();
    test_clear_req();
    test_clear_in_resp();
    test_mid_clear_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pa_f_spsram_64x44_ctrl.md
# pa_f_spsram_64x44_ctrl

Access controller that sits directly upstream of the 64x44 single-port SRAM model and owns its A/CEN/GWEN/WEN/D pins. It clears every entry after reset or on request, and turns a valid/ready request channel into SRAM write-with-bit-mask and read cycles. Read data is returned on a valid/ready response channel directly from the SRAM Q output. It relies on the SRAM's address-holding behaviour to keep Q stable while a response is back-pressured.

## Interface
- ADDR_WIDTH, 6, SRAM address width; depth = 2^ADDR_WIDTH
- DATA_WIDTH, 44, SRAM data width
- CLK  in  1  clock, shared with the SRAM
- RST  in  1  reset, synchronous, active-high
- clr_req  in  1  pulse: re-clear the whole array
- init_done  out  1  high when the array is cleared and requests are accepted
- req_vld  in  1  request valid
- req_rdy  out  1  request ready
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  entry index
- req_wdata  in  DATA_WIDTH  write data
- req_wmask  in  DATA_WIDTH  1 = write this bit (active-high; inverted onto WEN)
- rsp_vld  out  1  read data valid
- rsp_rdy  in  1  read data accepted
- rsp_data  out  DATA_WIDTH  read data, equal to SRAM Q
- A  out  ADDR_WIDTH  SRAM address
- CEN  out  1  SRAM chip enable, active-low
- GWEN  out  1  SRAM global write enable, active-low
- WEN  out  DATA_WIDTH  SRAM per-bit write enable, active-low
- D  out  DATA_WIDTH  SRAM write data
- Q  in  DATA_WIDTH  SRAM read data

## Operation
- **States:** INIT, IDLE, RESP. An internal ADDR_WIDTH-bit counter `init_cnt` is used during INIT.
- **Reset:** while RST=1, state←INIT and init_cnt←0. During reset cycles the outputs are CEN=1, GWEN=1, WEN=all 1, init_done=0, req_rdy=0, rsp_vld=0.
- **INIT:**
  - Every cycle drives CEN=0, GWEN=0, WEN=all 0, D=0, A=init_cnt, then init_cnt++.
  - On init_cnt = 2^ADDR_WIDTH−1, transition to IDLE and clear init_cnt to 0 (wrap).
  - req_rdy=0 and rsp_vld=0 throughout; req_vld and clr_req are ignored.
- **IDLE:**
  - init_done=1.
  - clr_req has priority: INIT next cycle, no SRAM access this cycle, and req_rdy=0 this cycle.
  - Otherwise req_rdy=1.
  - On req_vld & req_rdy:
    - CEN=0 and A=req_addr.
    - Write: GWEN=0, WEN=~req_wmask, D=req_wdata; stay in IDLE.
    - Read: GWEN=1, WEN=all 1; go to RESP.
  - With no accepted request: CEN=1, GWEN=1, WEN=all 1.
- **RESP:**
  - rsp_vld=1 and rsp_data=Q. The SRAM holds the read address, so Q stays stable while CEN=1.
  - If rsp_rdy=0: req_rdy=0 and CEN=1; stay in RESP.
  - If rsp_rdy=1:
    - req_rdy=1, and a new request may be accepted in the same cycle using the IDLE rules.
    - A read goes back to RESP.
    - A write or no request goes to IDLE.
    - clr_req in this cycle goes to INIT with req_rdy=0; the response is still consumed.
  - clr_req while rsp_rdy=0 is ignored (not queued).
- **Data path:**
  - A write fully masked (req_wmask=0) still issues CEN=0 but changes no bits.
  - There is no read/write forwarding; the SRAM serialises accesses.
- D and A may take any value when CEN=1.

## Timing
- **Clear time:** init_done rises exactly 2^ADDR_WIDTH cycles after the first non-reset cycle (64 by default). The same 64 cycles apply after clr_req is taken.
- **Write:** zero latency; the data is in the array after the accepting edge.
- **Read latency:** the request is accepted at edge N, and rsp_vld=1 in the cycle after edge N.
- **Throughput:**
  - Back-to-back reads run at 1 per cycle when rsp_rdy is held high.
  - Writes run at 1 per cycle.
- **Outputs:** A/CEN/GWEN/WEN/D are combinational from state, init_cnt and the request inputs. req_rdy depends on rsp_rdy and clr_req.
- **Reset mid-operation:** RST in any state aborts immediately. A pending response is dropped, and INIT restarts from entry 0.

## Test plan
- **Reset and clear:** hold RST 3 cycles, then release → 64 consecutive writes to A=0..63 with D=0. init_done=1 on cycle 65, then a read of addr 37 returns 0.
- **Masked write then read:** write addr 5 with data=0xFFF_FFFF_FFFF and mask=0x000_0000_FFFF, then read addr 5 → rsp_data=0x000_0000_FFFF, one cycle after the read is accepted.
- **Back-pressure:** read addr 5 with rsp_rdy=0 for 4 cycles → rsp_vld held, rsp_data stable, req_rdy=0 and CEN=1 throughout. Then rsp_rdy=1 together with a read of addr 6 → both handshakes happen in one cycle, and addr 6 data appears the next cycle.
- **Streaming:** 8 reads of addr 0..7 with rsp_rdy=1 → 8 responses on consecutive cycles, in order.
- **Clear request:** write 0xABC to addr 63, pulse clr_req in IDLE together with req_vld → request not accepted, 64 clear cycles run, and a later read of addr 63 returns 0.
- **Mid-clear reset:** assert RST at init_cnt=20 → INIT restarts at A=0, and init_done rises 64 cycles after release.
